sayeh_mem_if: RTL and testbench

- Memory-side bridge between the SAYEH controller/datapath and a single-port synchronous RAM.
- Consumes the controller's registered ReadMem/WriteMem strobes plus the address and data buses.
- Drives RAM enable, write-enable, address and write data.
- Returns read data with a one-cycle memDataReady pulse, after a programmable number of wait states.
- Lets the fetch/memread and exec1lda wait loops in the controller run against slow memory.

---
 rtl/sayeh_pkg.sv | 29 ++
 rtl/sayeh_wait_ctr.sv | 30 +++
 rtl/sayeh_mem_if.sv | 145 ++++++++++++++
 tb/tb_sayeh_mem_if.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sayeh_pkg.sv
// Shared definitions for the SAYEH memory bridge: state encoding, bus width
// defaults and the wait-state bound.
package sayeh_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;
   localparam int WAIT_MAX   = 15;
   localparam int CTR_W      = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_ISSUE = 3'd1,
      ST_RD_WAIT  = 3'd2,
      ST_RD_DONE  = 3'd3,
      ST_WR_ISSUE = 3'd4
   } state_e;

   // Out-of-range wait settings saturate instead of wrapping the counter.
   function automatic logic [CTR_W-1:0] clamp_wait(input int cycles);
      if (cycles < 0) begin
         return '0;
      end
      if (cycles > WAIT_MAX) begin
         return CTR_W'(WAIT_MAX);
      end
      return CTR_W'(cycles);
   endfunction

endpackage

// File: rtl/sayeh_wait_ctr.sv
// Loadable down-counter with a zero flag; counts RAM wait states for a read.
// Decrement saturates at zero so a held i_dec never wraps.
module sayeh_wait_ctr
   import sayeh_pkg::*;
#(
   parameter int W = CTR_W
) (
   input  logic         clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - {{(W-1){1'b0}}, 1'b1};
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/sayeh_mem_if.sv
// Memory-side bridge between the SAYEH controller and a single-port synchronous RAM.
// Reads go through a wait-state counter and finish with a one-cycle memDataReady pulse.
module sayeh_mem_if
   import sayeh_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              ExternalReset,
   input  logic              ReadMem,
   input  logic              WriteMem,
   input  logic [ADDR_W-1:0] AddressBus,
   input  logic [DATA_W-1:0] DataBusIn,
   output logic [DATA_W-1:0] DataBusOut,
   output logic              memDataReady,
   output logic              busy,
   output logic              proto_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [CTR_W-1:0] WAIT_LOAD = clamp_wait(WAIT_CYCLES);

   state_e            r_state;
   state_e            w_state_next;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_proto_err;

   logic w_accept_rd;
   logic w_accept_wr;
   logic w_err_set;
   logic w_ctr_load;
   logic w_ctr_dec;
   logic w_ctr_zero;
   logic w_capture;

   sayeh_wait_ctr #(
      .W(CTR_W)
   ) u_wait_ctr (
      .clk        (clk),
      .i_rst_n    (ExternalReset),
      .i_load     (w_ctr_load),
      .i_load_val (WAIT_LOAD),
      .i_dec      (w_ctr_dec),
      .o_zero     (w_ctr_zero)
   );

   always_ff @(posedge clk or negedge ExternalReset) begin
      if (!ExternalReset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ReadMem outside IDLE is the controller legally holding its strobe, so only
   // IDLE ever starts an access; a write strobe anywhere but IDLE is an error.
   always_comb begin
      w_state_next = r_state;
      w_accept_rd  = 1'b0;
      w_accept_wr  = 1'b0;
      w_err_set    = 1'b0;
      w_ctr_load   = 1'b0;
      w_ctr_dec    = 1'b0;
      w_capture    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (ReadMem) begin
               w_accept_rd  = 1'b1;
               w_err_set    = WriteMem;
               w_state_next = ST_RD_ISSUE;
            end else if (WriteMem) begin
               w_accept_wr  = 1'b1;
               w_state_next = ST_WR_ISSUE;
            end
         end
         ST_RD_ISSUE: begin
            w_ctr_load   = 1'b1;
            w_err_set    = WriteMem;
            w_state_next = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            w_ctr_dec = 1'b1;
            w_err_set = WriteMem;
            if (w_ctr_zero) begin
               w_capture    = 1'b1;
               w_state_next = ST_RD_DONE;
            end
         end
         ST_RD_DONE: begin
            w_err_set    = WriteMem;
            w_state_next = ST_IDLE;
         end
         ST_WR_ISSUE: begin
            w_err_set    = WriteMem;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Address/data registers update only on acceptance, so the RAM side holds
   // its last values whenever mem_en is low.
   always_ff @(posedge clk or negedge ExternalReset) begin
      if (!ExternalReset) begin
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_accept_rd || w_accept_wr) begin
            r_addr <= AddressBus;
         end
         if (w_accept_wr) begin
            r_wdata <= DataBusIn;
         end
         if (w_capture) begin
            r_rdata <= mem_rdata;
         end
         if (w_err_set) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   assign mem_en       = (r_state == ST_RD_ISSUE) || (r_state == ST_WR_ISSUE);
   assign mem_we       = (r_state == ST_WR_ISSUE);
   assign mem_addr     = r_addr;
   assign mem_wdata    = r_wdata;
   assign DataBusOut   = r_rdata;
   assign memDataReady = (r_state == ST_RD_DONE);
   assign busy         = (r_state != ST_IDLE);
   assign proto_err    = r_proto_err;

endmodule

// File: tb/tb_sayeh_mem_if.sv
// Directed bench for sayeh_mem_if: three instances (WAIT_CYCLES 0, 2, 15) on
// one clock and reset, each with its own latency-accurate RAM read pipe.
module tb_sayeh_mem_if;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_n;
   logic [2:0]          rd, wr, rdy, busy, perr, en, we;
   logic [2:0][15:0]    addr, din, dout, maddr, mwd, rdata;

   int n_cmp = 0;
   int n_err = 0;
   int wr_cnt = 0;
   int stray_wr_cnt = 0;

   logic [15:0] ram [0:255];
   logic        wv  [0:255] = '{default: 1'b0};

   function automatic logic [15:0] init_word(input logic [7:0] a);
      case (a)
         8'h00:   return 16'h2100;
         8'h05:   return 16'h00AA;
         8'h10:   return 16'hBEEF;
         8'h30:   return 16'h5A5A;
         default: return {8'hC0, a};
      endcase
   endfunction

   function automatic logic [15:0] ram_rd(input logic [7:0] a);
      return wv[a] ? ram[a] : init_word(a);
   endfunction

   // Only instance 1 may write the RAM; writes from the others are counted as stray.
   always @(posedge clk) begin
      if (en[1] && we[1]) begin
         ram[maddr[1][7:0]] <= mwd[1];
         wv[maddr[1][7:0]]  <= 1'b1;
         wr_cnt             <= wr_cnt + 1;
      end
      if ((en[0] && we[0]) || (en[2] && we[2])) begin
         stray_wr_cnt <= stray_wr_cnt + 1;
      end
   end

   for (genvar gi = 0; gi < 3; gi++) begin : g_inst
      localparam int WC = (gi == 0) ? 0 : (gi == 1) ? 2 : 15;
      logic [15:0] pipe [16];

      // Data read in the mem_en cycle is valid 1+WC cycles later; other cycles carry junk.
      always @(posedge clk) begin
         for (int k = 15; k > 0; k--) begin
            pipe[k] <= pipe[k-1];
         end
         pipe[0] <= (en[gi] && !we[gi]) ? ram_rd(maddr[gi][7:0]) : 16'h0BAD;
      end
      assign rdata[gi] = pipe[WC];

      sayeh_mem_if #(
         .ADDR_W      (16),
         .DATA_W      (16),
         .WAIT_CYCLES (WC)
      ) u_dut (
         .clk           (clk),
         .ExternalReset (rst_n),
         .ReadMem       (rd[gi]),
         .WriteMem      (wr[gi]),
         .AddressBus    (addr[gi]),
         .DataBusIn     (din[gi]),
         .DataBusOut    (dout[gi]),
         .memDataReady  (rdy[gi]),
         .busy          (busy[gi]),
         .proto_err     (perr[gi]),
         .mem_en        (en[gi]),
         .mem_we        (we[gi]),
         .mem_addr      (maddr[gi]),
         .mem_wdata     (mwd[gi]),
         .mem_rdata     (rdata[gi])
      );
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Ticks until memDataReady (bounded), then checks latency, data and RAM-enable pulses.
   task automatic wait_rdy(input int i, input int lat, input logic [15:0] expd, input int exp_en);
      int n;
      int ens;
      n   = 0;
      ens = 0;
      do begin
         tick();
         n++;
         if (en[i] && !we[i]) ens++;
      end while (!rdy[i] && n < 40);
      chk("rd_latency", n, lat);
      chk("rd_data", dout[i], expd);
      chk("rd_en_pulses", ens, exp_en);
      $display("read inst=%0d lat=%0d data=%04h", i, n, dout[i]);
   endtask

   task automatic do_read(input int i, input logic [15:0] a, input logic [15:0] expd, input int lat);
      rd[i]   = 1'b1;
      addr[i] = a;
      wait_rdy(i, lat, expd, 1);
   endtask

   initial begin
      int rdy_seen;
      rst_n = 1'b0;
      rd    = '0;
      wr    = '0;
      addr  = '0;
      din   = '0;
      tick();
      tick();

      chk("rst_dout",  dout[1],  16'h0);
      chk("rst_rdy",   rdy[1],   1'b0);
      chk("rst_busy",  busy[1],  1'b0);
      chk("rst_perr",  perr[1],  1'b0);
      chk("rst_en",    en[1],    1'b0);
      chk("rst_we",    we[1],    1'b0);
      chk("rst_maddr", maddr[1], 16'h0);
      chk("rst_mwd",   mwd[1],   16'h0);
      $display("reset outputs checked");
      rst_n = 1'b1;
      tick();

      // Read 0x0010, WAIT_CYCLES=2: ready 5 cycles after acceptance, strobe held through RD_DONE
      do_read(1, 16'h0010, 16'hBEEF, 5);
      tick();
      chk("hold_rdy",  rdy[1],  1'b0);
      chk("hold_busy", busy[1], 1'b0);
      chk("hold_data", dout[1], 16'hBEEF);
      rd[1] = 1'b0;

      // Write 0x0020 <= 0x1234, then read it back in the cycle after WR_ISSUE
      wr[1]   = 1'b1;
      addr[1] = 16'h0020;
      din[1]  = 16'h1234;
      tick();
      chk("wr_en",    en[1],    1'b1);
      chk("wr_we",    we[1],    1'b1);
      chk("wr_addr",  maddr[1], 16'h0020);
      chk("wr_wdata", mwd[1],   16'h1234);
      chk("wr_rdy",   rdy[1],   1'b0);
      wr[1]  = 1'b0;
      din[1] = 16'h0000;
      tick();
      chk("wr_idle_en",    en[1],  1'b0);
      chk("wr_idle_rdy",   rdy[1], 1'b0);
      chk("wr_keep_dout",  dout[1], 16'hBEEF);
      chk("wr_keep_wdata", mwd[1],  16'h1234);
      chk("wr_count",      wr_cnt,  1);
      $display("write inst=1 addr=0020 data=1234");
      do_read(1, 16'h0020, 16'h1234, 5);
      tick();
      rd[1] = 1'b0;

      // Back-to-back fetch -> lda on WAIT_CYCLES=0
      do_read(0, 16'h0000, 16'h2100, 3);
      tick();
      chk("b2b_no_stale_access", busy[0], 1'b0);
      do_read(0, 16'h0005, 16'h00AA, 3);
      tick();
      rd[0] = 1'b0;
      chk("b2b_rdy_low", rdy[0], 1'b0);

      // WAIT_CYCLES=15: latency 18
      do_read(2, 16'h0030, 16'h5A5A, 18);
      tick();
      rd[2] = 1'b0;

      // WriteMem during RD_WAIT: flagged, dropped, read still completes
      rd[1]   = 1'b1;
      addr[1] = 16'h0010;
      tick();
      tick();
      chk("perr_before", perr[1], 1'b0);
      wr[1]  = 1'b1;
      din[1] = 16'hFFFF;
      tick();
      wr[1] = 1'b0;
      chk("perr_set", perr[1], 1'b1);
      wait_rdy(1, 2, 16'hBEEF, 0);
      tick();
      rd[1] = 1'b0;
      tick();
      tick();
      chk("perr_sticky",   perr[1], 1'b1);
      chk("dropped_write", wr_cnt,  2'd1);
      $display("proto inst=1 write-while-busy perr=%0b", perr[1]);

      // Both strobes in IDLE: flagged, read only
      rd[0]   = 1'b1;
      wr[0]   = 1'b1;
      addr[0] = 16'h0030;
      din[0]  = 16'h7777;
      tick();
      wr[0] = 1'b0;
      chk("both_perr", perr[0], 1'b1);
      chk("both_en",   en[0],   1'b1);
      chk("both_we",   we[0],   1'b0);
      wait_rdy(0, 2, 16'h5A5A, 0);
      tick();
      rd[0] = 1'b0;
      chk("both_no_write", stray_wr_cnt, 0);
      $display("proto inst=0 both-strobes perr=%0b", perr[0]);

      // Asynchronous reset in the middle of RD_WAIT
      rd[1]   = 1'b1;
      addr[1] = 16'h0010;
      tick();
      tick();
      chk("pre_rst_busy", busy[1], 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy",  busy[1],  1'b0);
      chk("arst_en",    en[1],    1'b0);
      chk("arst_rdy",   rdy[1],   1'b0);
      chk("arst_dout",  dout[1],  16'h0);
      chk("arst_perr",  perr[1],  1'b0);
      chk("arst_maddr", maddr[1], 16'h0);
      chk("arst_perr0", perr[0],  1'b0);
      rd[1] = 1'b0;
      tick();
      rst_n = 1'b1;
      rdy_seen = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (rdy[1]) rdy_seen++;
      end
      chk("arst_no_ready", rdy_seen, 0);
      $display("async reset mid-read abandoned access");
      do_read(1, 16'h0010, 16'hBEEF, 5);
      tick();
      rd[1] = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
